// File: rtl/exp10_pkg.sv
`default_nettype none
// ============================================================================
// Module  : exp10_pkg
// Brief   : Q16.16 constants, 1/n table and state encoding for exp10_fixed.
// Revision: 1.0 - initial release
// ============================================================================
package exp10_pkg;

    localparam logic signed [31:0] LOG2_10       = 32'sh0003526A;
    localparam logic signed [31:0] LOG2_10_DIV20 = 32'sh00002A85;
    localparam logic signed [31:0] LN2           = 32'sh0000B172;
    localparam logic signed [31:0] ONE           = 32'sh00010000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCALE  = 3'd1,
        S_SPLIT  = 3'd2,
        S_SERIES = 3'd3,
        S_SHIFT  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // 1/n in Q16.16 for the Taylor coefficients of e^z
    function automatic logic signed [31:0] recip(input logic [3:0] n);
        case (n)
            4'd1:    recip = 32'sd65536;
            4'd2:    recip = 32'sd32768;
            4'd3:    recip = 32'sd21845;
            4'd4:    recip = 32'sd16384;
            4'd5:    recip = 32'sd13107;
            4'd6:    recip = 32'sd10923;
            4'd7:    recip = 32'sd9362;
            4'd8:    recip = 32'sd8192;
            default: recip = 32'sd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/exp10_shift_sat.sv
`default_nettype none
// ============================================================================
// Module  : exp10_shift_sat
// Brief   : Scales the [1,2) mantissa by 2^k with saturation and underflow.
// Revision: 1.0 - initial release
// ============================================================================
module exp10_shift_sat #(
    parameter int Q = 16,
    parameter int N = 32
) (
    input  logic signed [N-1:0]   sum,
    input  logic signed [N-Q-1:0] k,
    output logic signed [N-1:0]   out_x,
    output logic                  overflow
);

    localparam int KW = N - Q;
    localparam logic signed [KW-1:0] K_MAX = KW'(N - Q - 2);
    localparam logic signed [KW-1:0] K_MIN = KW'(-(Q + 1));

    logic signed [KW-1:0] w_neg_k;

    assign w_neg_k = -k;

    always_comb begin
        out_x    = '0;
        overflow = 1'b0;
        if (k > K_MAX) begin
            out_x    = {1'b0, {(N-1){1'b1}}};
            overflow = 1'b1;
        end else if (k < K_MIN) begin
            out_x = '0;
        end else if (!k[KW-1]) begin
            out_x = sum << k;
        end else begin
            out_x = sum >>> w_neg_k;
        end
    end

endmodule
`default_nettype wire

// File: rtl/qmult.sv
`default_nettype none
// ============================================================================
// Module  : qmult
// Brief   : Signed fixed-point multiply, full product truncated to Q format.
// Revision: 1.0 - initial release
// ============================================================================
module qmult #(
    parameter int Q = 16,
    parameter int N = 32
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic signed [N-1:0] y
);

    logic signed [2*N-1:0] w_full;

    assign w_full = (2*N)'(a) * (2*N)'(b);
    assign y      = w_full[N-1+Q:Q];

endmodule
`default_nettype wire

// File: rtl/exp10_fixed.sv
`default_nettype none
// ============================================================================
// Module  : exp10_fixed
// Brief   : Sequential Q16.16 antilog, out_x = 10^in_x (10^(in_x/20) when
//           EXP10_DB20_EN is defined), via 2^k * e^(f*ln2) Taylor series.
// Revision: 1.0 - initial release
// ============================================================================
module exp10_fixed #(
    parameter int Q     = 16,
    parameter int N     = 32,
    parameter int TERMS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_exp10,
    input  logic signed [N-1:0] in_x,
    output logic signed [N-1:0] out_x,
    output logic                done_exp10,
    output logic                busy,
    output logic                overflow
);
    import exp10_pkg::*;

`ifdef EXP10_DB20_EN
    localparam logic signed [N-1:0] SCALE_C = LOG2_10_DIV20;
`else
    localparam logic signed [N-1:0] SCALE_C = LOG2_10;
`endif
    localparam logic [3:0] LAST_N = 4'(TERMS - 1);

    state_t                r_state;
    logic signed [N-1:0]   r_x, r_y, r_z, r_term, r_sum;
    logic signed [N-Q-1:0] r_k;
    logic [3:0]            r_n;

    logic signed [N-1:0]   w_a, w_b, w_p0, w_p1, w_recip, w_frac;
    logic signed [N-1:0]   w_shift_out;
    logic                  w_shift_ovf;

    assign w_frac  = {{(N-Q){1'b0}}, r_y[Q-1:0]};
    assign w_recip = recip(r_n);

    // The first multiplier is time-shared: scale, then f*ln2, then term*z
    always_comb begin
        w_a = r_term;
        w_b = r_z;
        case (r_state)
            S_SCALE: begin
                w_a = r_x;
                w_b = SCALE_C;
            end
            S_SPLIT: begin
                w_a = w_frac;
                w_b = LN2;
            end
            default: ;
        endcase
    end

    qmult #(.Q(Q), .N(N)) u_mul_a (.a(w_a),  .b(w_b),     .y(w_p0));
    qmult #(.Q(Q), .N(N)) u_mul_b (.a(w_p0), .b(w_recip), .y(w_p1));

    exp10_shift_sat #(.Q(Q), .N(N)) u_shift_sat (
        .sum      (r_sum),
        .k        (r_k),
        .out_x    (w_shift_out),
        .overflow (w_shift_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            out_x      <= '0;
            done_exp10 <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done_exp10 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_exp10) begin
                        r_x     <= in_x;
                        busy    <= 1'b1;
                        r_state <= S_SCALE;
                    end
                end
                S_SCALE: begin
                    r_y     <= w_p0;
                    r_state <= S_SPLIT;
                end
                S_SPLIT: begin
                    r_k     <= r_y[N-1:Q];
                    r_z     <= w_p0;
                    r_term  <= ONE;
                    r_sum   <= ONE;
                    r_n     <= 4'd1;
                    r_state <= S_SERIES;
                end
                S_SERIES: begin
                    r_term <= w_p1;
                    r_sum  <= r_sum + w_p1;
                    r_n    <= r_n + 4'd1;
                    if (r_n == LAST_N) begin
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    out_x      <= w_shift_out;
                    overflow   <= w_shift_ovf;
                    done_exp10 <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
